// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG debug transport module.
package jtag_pkg;

    // IEEE 1149.1 TAP controller states
    typedef enum logic [3:0] {
        TAP_TLR,
        TAP_RTI,
        TAP_SEL_DR,
        TAP_CAP_DR,
        TAP_SH_DR,
        TAP_EX1_DR,
        TAP_PAUSE_DR,
        TAP_EX2_DR,
        TAP_UPD_DR,
        TAP_SEL_IR,
        TAP_CAP_IR,
        TAP_SH_IR,
        TAP_EX1_IR,
        TAP_PAUSE_IR,
        TAP_EX2_IR,
        TAP_UPD_IR
    } tap_state_e;

    // Instruction codes; anything else selects BYPASS
    localparam logic [4:0] IR_IDCODE  = 5'h01;
    localparam logic [4:0] IR_DTMCS   = 5'h10;
    localparam logic [4:0] IR_DMI     = 5'h11;
    localparam logic [4:0] IR_CAPTURE = 5'b00001;

    // DMI op field on update, and status reported back on capture
    localparam logic [1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;
    localparam logic [1:0] DMI_OP_BUSY  = 2'd3;
    localparam logic [1:0] DMI_RESP_OK     = 2'd0;
    localparam logic [1:0] DMI_RESP_FAILED = 2'd2;

    // DTMCS bit positions
    localparam int DTMCS_DMIRESET     = 16;
    localparam int DTMCS_DMIHARDRESET = 17;

    // DTMCS read-back word: idle field = 1, version field = 1
    function automatic logic [31:0] dtmcs_word(input logic [1:0] stat, input logic [5:0] abits);
        return {14'b0, 1'b0, 1'b0, 1'b0, 3'd1, stat, abits, 4'd1};
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP controller: 16-state machine stepped by synchronized TCK rising edges.
// The phase strobes are plain "currently in state X" flags; the caller
// qualifies them with the TCK rising edge.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       trst_i,
    input  logic       step_i,
    input  logic       tms_i,
    output tap_state_e state_o,
    output logic       capture_ir_o,
    output logic       shift_ir_o,
    output logic       update_ir_o,
    output logic       capture_dr_o,
    output logic       shift_dr_o,
    output logic       update_dr_o
);

    tap_state_e state_q, state_d;

    // State register; TRST pins the controller in Test-Logic-Reset
    always_ff @(posedge clk) begin
        if (!reset || trst_i) state_q <= TAP_TLR;
        else                  state_q <= state_d;
    end

    // Next-state on each TCK rise, plus phase flags decoded from the current state
    always_comb begin
        state_d      = state_q;
        capture_ir_o = 1'b0;
        shift_ir_o   = 1'b0;
        update_ir_o  = 1'b0;
        capture_dr_o = 1'b0;
        shift_dr_o   = 1'b0;
        update_dr_o  = 1'b0;
        if (step_i) begin
            case (state_q)
                TAP_TLR:      state_d = tms_i ? TAP_TLR    : TAP_RTI;
                TAP_RTI:      state_d = tms_i ? TAP_SEL_DR : TAP_RTI;
                TAP_SEL_DR:   state_d = tms_i ? TAP_SEL_IR : TAP_CAP_DR;
                TAP_CAP_DR:   state_d = tms_i ? TAP_EX1_DR : TAP_SH_DR;
                TAP_SH_DR:    state_d = tms_i ? TAP_EX1_DR : TAP_SH_DR;
                TAP_EX1_DR:   state_d = tms_i ? TAP_UPD_DR : TAP_PAUSE_DR;
                TAP_PAUSE_DR: state_d = tms_i ? TAP_EX2_DR : TAP_PAUSE_DR;
                TAP_EX2_DR:   state_d = tms_i ? TAP_UPD_DR : TAP_SH_DR;
                TAP_UPD_DR:   state_d = tms_i ? TAP_SEL_DR : TAP_RTI;
                TAP_SEL_IR:   state_d = tms_i ? TAP_TLR    : TAP_CAP_IR;
                TAP_CAP_IR:   state_d = tms_i ? TAP_EX1_IR : TAP_SH_IR;
                TAP_SH_IR:    state_d = tms_i ? TAP_EX1_IR : TAP_SH_IR;
                TAP_EX1_IR:   state_d = tms_i ? TAP_UPD_IR : TAP_PAUSE_IR;
                TAP_PAUSE_IR: state_d = tms_i ? TAP_EX2_IR : TAP_PAUSE_IR;
                TAP_EX2_IR:   state_d = tms_i ? TAP_UPD_IR : TAP_SH_IR;
                TAP_UPD_IR:   state_d = tms_i ? TAP_SEL_DR : TAP_RTI;
                default:      state_d = TAP_TLR;
            endcase
        end
        capture_ir_o = (state_q == TAP_CAP_IR);
        shift_ir_o   = (state_q == TAP_SH_IR);
        update_ir_o  = (state_q == TAP_UPD_IR);
        capture_dr_o = (state_q == TAP_CAP_DR);
        shift_dr_o   = (state_q == TAP_SH_DR);
        update_dr_o  = (state_q == TAP_UPD_DR);
    end

    assign state_o = state_q;

endmodule

// File: rtl/jtag_dtm_responder.sv
// Target-side JTAG DTM: oversampled pins, TAP, IR/DR registers and DMI request/response handshake.
module jtag_dtm_responder
    import jtag_pkg::*;
#(
    parameter int          ABITS  = 7,
    parameter logic [31:0] IDCODE = 32'h00000001,
    parameter int          SYNC   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             jtag_TCK,
    input  logic             jtag_TMS,
    input  logic             jtag_TDI,
    input  logic             jtag_TRST,
    output logic             jtag_TDO,
    output logic             jtag_TDO_en,
    output logic             dmi_req_valid,
    input  logic             dmi_req_ready,
    output logic [ABITS-1:0] dmi_req_addr,
    output logic [31:0]      dmi_req_data,
    output logic [1:0]       dmi_req_op,
    input  logic             dmi_resp_valid,
    output logic             dmi_resp_ready,
    input  logic [31:0]      dmi_resp_data,
    input  logic [1:0]       dmi_resp_resp,
    output logic             dmi_hard_reset
);

    localparam int DRW = ABITS + 34;

    logic [SYNC-1:0]  tck_sync_q, tms_sync_q, tdi_sync_q, trst_sync_q;
    logic             tck_prev_q;
    logic             tck_s, tms_s, tdi_s, trst_s, tck_rise, tck_fall;
    tap_state_e       tap_state;
    logic             cap_ir, sh_ir, upd_ir, cap_dr, sh_dr, upd_dr;
    logic [4:0]       ir_q, ir_shift_q;
    logic [DRW-1:0]   dr_q;
    logic             busy_q, sticky_q, req_valid_q, hard_reset_q, tdo_q, tdo_en_q;
    logic [ABITS-1:0] req_addr_q, last_addr_q;
    logic [31:0]      req_data_q, last_rdata_q;
    logic [1:0]       req_op_q, last_resp_q;

    // Pin synchronizers and TCK edge history
    always_ff @(posedge clk) begin
        if (!reset) begin
            tck_sync_q  <= '0;
            tms_sync_q  <= '0;
            tdi_sync_q  <= '0;
            trst_sync_q <= '0;
            tck_prev_q  <= 1'b0;
        end else begin
            tck_sync_q  <= (tck_sync_q << 1)  | SYNC'(jtag_TCK);
            tms_sync_q  <= (tms_sync_q << 1)  | SYNC'(jtag_TMS);
            tdi_sync_q  <= (tdi_sync_q << 1)  | SYNC'(jtag_TDI);
            trst_sync_q <= (trst_sync_q << 1) | SYNC'(jtag_TRST);
            tck_prev_q  <= tck_s;
        end
    end

    assign tck_s    = tck_sync_q[SYNC-1];
    assign tms_s    = tms_sync_q[SYNC-1];
    assign tdi_s    = tdi_sync_q[SYNC-1];
    assign trst_s   = trst_sync_q[SYNC-1];
    assign tck_rise = tck_s & ~tck_prev_q;
    assign tck_fall = ~tck_s & tck_prev_q;

    jtag_tap_fsm u_tap (
        .clk          (clk),
        .reset        (reset),
        .trst_i       (trst_s),
        .step_i       (tck_rise),
        .tms_i        (tms_s),
        .state_o      (tap_state),
        .capture_ir_o (cap_ir),
        .shift_ir_o   (sh_ir),
        .update_ir_o  (upd_ir),
        .capture_dr_o (cap_dr),
        .shift_dr_o   (sh_dr),
        .update_dr_o  (upd_dr)
    );

    // A response completing in the same clk as Capture-DR must be visible to that capture,
    // so the captured status is built from the post-handshake view of busy/rdata/resp.
    logic             resp_fire, busy_now, upd_dmi, upd_dtmcs;
    logic [31:0]      rdata_now;
    logic [1:0]       resp_now, stat_now, dr_op;
    logic [31:0]      dr_data;
    logic [ABITS-1:0] dr_addr;

    assign dmi_resp_ready = busy_q & ~req_valid_q;
    assign resp_fire      = dmi_resp_ready & dmi_resp_valid;
    assign rdata_now      = resp_fire ? dmi_resp_data : last_rdata_q;
    assign resp_now       = resp_fire ? dmi_resp_resp : last_resp_q;
    assign busy_now       = busy_q & ~resp_fire;
    assign stat_now       = (busy_now | sticky_q) ? DMI_OP_BUSY : resp_now;
    assign upd_dmi        = tck_rise & upd_dr & (ir_q == IR_DMI);
    assign upd_dtmcs      = tck_rise & upd_dr & (ir_q == IR_DTMCS);
    assign dr_op          = dr_q[1:0];
    assign dr_data        = dr_q[33:2];
    assign dr_addr        = dr_q[DRW-1:34];

    // Instruction register: capture/shift/update, forced to IDCODE in Test-Logic-Reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            ir_q       <= IR_IDCODE;
            ir_shift_q <= '0;
        end else if (trst_s || tap_state == TAP_TLR) begin
            ir_q <= IR_IDCODE;
        end else if (tck_rise) begin
            if (cap_ir)      ir_shift_q <= IR_CAPTURE;
            else if (sh_ir)  ir_shift_q <= {tdi_s, ir_shift_q[4:1]};
            else if (upd_ir) ir_q       <= ir_shift_q;
        end
    end

    // Data register: capture per instruction, shift TDI into the MSB of the selected length
    always_ff @(posedge clk) begin
        if (!reset) begin
            dr_q <= '0;
        end else if (tck_rise && cap_dr) begin
            case (ir_q)
                IR_IDCODE: dr_q <= DRW'(IDCODE);
                IR_DTMCS:  dr_q <= DRW'(dtmcs_word(stat_now, 6'(ABITS)));
                IR_DMI:    dr_q <= {last_addr_q, rdata_now, stat_now};
                default:   dr_q <= '0;
            endcase
        end else if (tck_rise && sh_dr) begin
            case (ir_q)
                IR_IDCODE, IR_DTMCS: dr_q[31:0] <= {tdi_s, dr_q[31:1]};
                IR_DMI:              dr_q       <= {tdi_s, dr_q[DRW-1:1]};
                default:             dr_q[0]    <= tdi_s;
            endcase
        end
    end

    // DMI request/response bookkeeping, sticky error and DTMCS reset controls
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q       <= 1'b0;
            sticky_q     <= 1'b0;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
            req_data_q   <= '0;
            req_op_q     <= '0;
            last_addr_q  <= '0;
            last_rdata_q <= '0;
            last_resp_q  <= DMI_RESP_OK;
            hard_reset_q <= 1'b0;
        end else begin
            hard_reset_q <= 1'b0;
            if (req_valid_q && dmi_req_ready) req_valid_q <= 1'b0;
            if (resp_fire) begin
                last_rdata_q <= dmi_resp_data;
                last_resp_q  <= dmi_resp_resp;
                busy_q       <= 1'b0;
            end
            if (upd_dmi) begin
                if (busy_q) begin
                    sticky_q <= 1'b1;
                end else if (!sticky_q && (dr_op == DMI_OP_READ || dr_op == DMI_OP_WRITE)) begin
                    req_addr_q  <= dr_addr;
                    req_data_q  <= dr_data;
                    req_op_q    <= dr_op;
                    last_addr_q <= dr_addr;
                    req_valid_q <= 1'b1;
                    busy_q      <= 1'b1;
                end
            end
            if (upd_dtmcs) begin
                if (dr_q[DTMCS_DMIRESET]) sticky_q <= 1'b0;
                if (dr_q[DTMCS_DMIHARDRESET]) begin
                    sticky_q     <= 1'b0;
                    busy_q       <= 1'b0;
                    req_valid_q  <= 1'b0;
                    hard_reset_q <= 1'b1;
                end
            end
        end
    end

    // TDO and its enable change on TCK falling edges only
    always_ff @(posedge clk) begin
        if (!reset) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else if (tck_fall) begin
            tdo_en_q <= sh_ir | sh_dr;
            tdo_q    <= sh_ir ? ir_shift_q[0] : (sh_dr ? dr_q[0] : 1'b0);
        end
    end

    assign jtag_TDO       = tdo_q;
    assign jtag_TDO_en    = tdo_en_q;
    assign dmi_req_valid  = req_valid_q;
    assign dmi_req_addr   = req_addr_q;
    assign dmi_req_data   = req_data_q;
    assign dmi_req_op     = req_op_q;
    assign dmi_hard_reset = hard_reset_q;

endmodule

// File: tb/tb_jtag_dtm_responder.sv
// Bench for jtag_dtm_responder: bit-banged JTAG host plus a small Debug Module model.
`timescale 1ns/1ps
module tb_jtag_dtm_responder;
    import jtag_pkg::*;

    localparam logic [31:0] IDCODE_V = 32'h10E31913;
    localparam logic [31:0] DTMCS_IDLE = 32'h00001071;
    localparam logic [31:0] DTMCS_BUSY = 32'h00001C71;

    logic        clk = 1'b0;
    logic        reset;
    logic        jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRST;
    logic        jtag_TDO, jtag_TDO_en;
    logic        dmi_req_valid, dmi_req_ready;
    logic [6:0]  dmi_req_addr;
    logic [31:0] dmi_req_data;
    logic [1:0]  dmi_req_op;
    logic        dmi_resp_valid, dmi_resp_ready;
    logic [31:0] dmi_resp_data;
    logic [1:0]  dmi_resp_resp;
    logic        dmi_hard_reset;

    int total_cnt = 0;
    int bad_cnt = 0;
    int stable_err = 0;
    int hs_cnt = 0;
    int hr_cnt = 0;
    logic dm_hold = 1'b0;
    logic dm_block = 1'b0;
    logic [31:0] mem [128];
    logic [63:0] exp_q[$];
    logic [63:0] req_exp_q[$];

    jtag_dtm_responder #(.ABITS(7), .IDCODE(IDCODE_V), .SYNC(2)) dut (
        .clk(clk), .reset(reset),
        .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TRST(jtag_TRST),
        .jtag_TDO(jtag_TDO), .jtag_TDO_en(jtag_TDO_en),
        .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
        .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
        .dmi_resp_valid(dmi_resp_valid), .dmi_resp_ready(dmi_resp_ready),
        .dmi_resp_data(dmi_resp_data), .dmi_resp_resp(dmi_resp_resp),
        .dmi_hard_reset(dmi_hard_reset)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin : watchdog
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: run exceeded 60000 clk, bad=%0d", bad_cnt);
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d, input logic [1:0] o);
        return 64'({a, d, o});
    endfunction

    // driver tasks: one TCK period with TMS/TDI set up while TCK is low
    task automatic tck_pulse(input logic tms, input logic tdi, output logic tdo, output logic en);
        jtag_TMS = tms;
        jtag_TDI = tdi;
        repeat (4) @(negedge clk);
        tdo = jtag_TDO;
        en  = jtag_TDO_en;
        jtag_TCK = 1'b1;
        repeat (4) @(negedge clk);
        jtag_TCK = 1'b0;
    endtask

    task automatic tms_reset();
        logic o, e;
        repeat (5) tck_pulse(1'b1, 1'b0, o, e);
    endtask

    task automatic goto_idle();
        logic o, e;
        tck_pulse(1'b0, 1'b0, o, e);
    endtask

    // RTI -> shift IR -> RTI; checks the captured IR pattern
    task automatic scan_ir(input logic [4:0] v);
        logic o, e;
        logic [4:0] cap;
        cap = '0;
        tck_pulse(1'b1, 1'b0, o, e);
        tck_pulse(1'b1, 1'b0, o, e);
        tck_pulse(1'b0, 1'b0, o, e);
        tck_pulse(1'b0, 1'b0, o, e);
        for (int i = 0; i < 5; i++) begin
            tck_pulse(i == 4, v[i], o, e);
            cap[i] = o;
        end
        tck_pulse(1'b1, 1'b0, o, e);
        tck_pulse(1'b0, 1'b0, o, e);
        check_val("ir_capture", 64'(cap), 64'(5'b00001));
    endtask

    // RTI -> shift len DR bits (LSB first) -> update -> RTI
    task automatic scan_dr(input int len, input logic [63:0] din, output logic [63:0] dout, output logic en0);
        logic o, e;
        dout = '0;
        en0  = 1'b0;
        tck_pulse(1'b1, 1'b0, o, e);
        tck_pulse(1'b0, 1'b0, o, e);
        tck_pulse(1'b0, 1'b0, o, e);
        for (int i = 0; i < len; i++) begin
            tck_pulse(i == len - 1, din[i], o, e);
            dout[i] = o;
            if (i == 0) en0 = e;
        end
        tck_pulse(1'b1, 1'b0, o, e);
        tck_pulse(1'b0, 1'b0, o, e);
    endtask

    // scoreboard: expected capture queued with the stimulus, popped when the scan completes
    task automatic scan_chk(input string tag, input int len, input logic [63:0] din, input logic [63:0] exp);
        logic [63:0] dout;
        logic en0;
        exp_q.push_back(exp);
        scan_dr(len, din, dout, en0);
        check_val(tag, dout, exp_q.pop_front());
    endtask

    // Debug Module model: ready after 3 clk, response 2 clk after acceptance
    initial begin : dm_model
        logic [6:0]  a;
        logic [31:0] d, rd;
        logic [1:0]  o;
        int n;
        dmi_req_ready = 1'b0;
        dmi_resp_valid = 1'b0;
        dmi_resp_data = '0;
        dmi_resp_resp = '0;
        forever begin
            @(negedge clk);
            if (dmi_req_valid && !dm_block) begin
                a = dmi_req_addr;
                d = dmi_req_data;
                o = dmi_req_op;
                repeat (3) begin
                    @(negedge clk);
                    if (!dmi_req_valid || {dmi_req_addr, dmi_req_data, dmi_req_op} != {a, d, o})
                        stable_err++;
                end
                dmi_req_ready = 1'b1;
                @(negedge clk);
                dmi_req_ready = 1'b0;
                hs_cnt++;
                check_val("req_valid_drop", 64'(dmi_req_valid), 64'd0);
                if (req_exp_q.size() == 0) check_val("req_expected", 64'(req_exp_q.size()), 64'd1);
                else check_val("req_fields", dmi_word(a, d, o), req_exp_q.pop_front());
                if (o == DMI_OP_READ) rd = mem[a];
                else begin
                    mem[a] = d;
                    rd = '0;
                end
                n = 0;
                while (dm_hold && n < 20000) begin
                    @(negedge clk);
                    n++;
                end
                repeat (2) @(negedge clk);
                check_val("resp_ready", 64'(dmi_resp_ready), 64'd1);
                dmi_resp_valid = 1'b1;
                dmi_resp_data = rd;
                dmi_resp_resp = DMI_RESP_OK;
                @(negedge clk);
                dmi_resp_valid = 1'b0;
                dmi_resp_data = '0;
            end
        end
    end

    initial begin : hard_reset_mon
        forever begin
            @(negedge clk);
            if (dmi_hard_reset) hr_cnt++;
        end
    end

    // main sequence
    initial begin : main_seq
        logic [63:0] dout;
        logic en0;
        int n;
        for (int i = 0; i < 128; i++) mem[i] = '0;
        mem[7'h11] = 32'h12345678;
        mem[7'h05] = 32'hCAFE0005;
        reset = 1'b0;
        jtag_TCK = 1'b0;
        jtag_TMS = 1'b0;
        jtag_TDI = 1'b0;
        jtag_TRST = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_outputs",
                  64'({jtag_TDO, jtag_TDO_en, dmi_req_valid, dmi_resp_ready, dmi_hard_reset,
                       dmi_req_addr, dmi_req_data, dmi_req_op}), 64'd0);
        check_val("reset_tap", 64'(dut.u_tap.state_o), 64'(TAP_TLR));
        reset = 1'b1;

        // TRST then TMS reset, IDCODE readout
        jtag_TRST = 1'b1;
        repeat (4) @(negedge clk);
        jtag_TRST = 1'b0;
        repeat (3) @(negedge clk);
        tms_reset();
        check_val("tap_tlr", 64'(dut.u_tap.state_o), 64'(TAP_TLR));
        goto_idle();
        check_val("tap_rti", 64'(dut.u_tap.state_o), 64'(TAP_RTI));
        exp_q.push_back(64'(IDCODE_V));
        scan_dr(32, 64'd0, dout, en0);
        check_val("idcode", dout, exp_q.pop_front());
        check_val("tdo_en_shift", 64'(en0), 64'd1);
        check_val("tdo_en_idle", 64'(jtag_TDO_en), 64'd0);

        // BYPASS: one-bit delay after a captured 0
        scan_ir(5'h1F);
        scan_chk("bypass", 9, 64'h0A5, 64'h14A);

        // DTMCS read-back
        scan_ir(IR_DTMCS);
        scan_chk("dtmcs", 32, 64'd0, 64'(DTMCS_IDLE));

        // DMI write then read
        scan_ir(IR_DMI);
        req_exp_q.push_back(dmi_word(7'h10, 32'hDEADBEEF, DMI_OP_WRITE));
        scan_chk("dmi_cap_first", 41, dmi_word(7'h10, 32'hDEADBEEF, DMI_OP_WRITE), 64'd0);
        req_exp_q.push_back(dmi_word(7'h11, 32'h0, DMI_OP_READ));
        scan_chk("dmi_cap_after_wr", 41, dmi_word(7'h11, 32'h0, DMI_OP_READ),
                 dmi_word(7'h10, 32'h0, DMI_RESP_OK));
        scan_chk("dmi_read_data", 41, 64'd0, dmi_word(7'h11, 32'h12345678, DMI_RESP_OK));

        // update while busy -> sticky; cleared through dtmcs.dmireset
        dm_hold = 1'b1;
        req_exp_q.push_back(dmi_word(7'h05, 32'h0, DMI_OP_READ));
        scan_chk("dmi_cap_pre_busy", 41, dmi_word(7'h05, 32'h0, DMI_OP_READ),
                 dmi_word(7'h11, 32'h12345678, DMI_RESP_OK));
        scan_chk("dmi_cap_busy", 41, dmi_word(7'h06, 32'h11111111, DMI_OP_WRITE),
                 dmi_word(7'h05, 32'h12345678, DMI_OP_BUSY));
        scan_chk("dmi_cap_sticky", 41, 64'd0, dmi_word(7'h05, 32'h12345678, DMI_OP_BUSY));
        dm_hold = 1'b0;
        repeat (20) @(negedge clk);
        scan_ir(IR_DTMCS);
        scan_chk("dtmcs_sticky", 32, 64'h1 << DTMCS_DMIRESET, 64'(DTMCS_BUSY));
        scan_ir(IR_DMI);
        req_exp_q.push_back(dmi_word(7'h20, 32'h55AA00FF, DMI_OP_WRITE));
        scan_chk("dmi_cap_cleared", 41, dmi_word(7'h20, 32'h55AA00FF, DMI_OP_WRITE),
                 dmi_word(7'h05, 32'hCAFE0005, DMI_RESP_OK));
        req_exp_q.push_back(dmi_word(7'h20, 32'h0, DMI_OP_READ));
        scan_chk("dmi_cap_wr20", 41, dmi_word(7'h20, 32'h0, DMI_OP_READ),
                 dmi_word(7'h20, 32'h0, DMI_RESP_OK));
        scan_chk("dmi_read20", 41, 64'd0, dmi_word(7'h20, 32'h55AA00FF, DMI_RESP_OK));

        // hard reset drops a request the DM never accepted
        dm_block = 1'b1;
        scan_chk("dmi_cap_pre_hr", 41, dmi_word(7'h07, 32'h0, DMI_OP_READ),
                 dmi_word(7'h20, 32'h55AA00FF, DMI_RESP_OK));
        check_val("req_pending", 64'(dmi_req_valid), 64'd1);
        scan_ir(IR_DTMCS);
        scan_chk("dtmcs_busy", 32, 64'h1 << DTMCS_DMIHARDRESET, 64'(DTMCS_BUSY));
        check_val("req_dropped", 64'(dmi_req_valid), 64'd0);
        check_val("hard_reset_pulses", 64'(hr_cnt), 64'd1);
        dm_block = 1'b0;
        scan_ir(IR_DMI);
        scan_chk("dmi_cap_after_hr", 41, 64'd0, dmi_word(7'h07, 32'h55AA00FF, DMI_RESP_OK));

        // TMS reset returns IR to IDCODE
        tms_reset();
        check_val("tap_tlr_tms", 64'(dut.u_tap.state_o), 64'(TAP_TLR));
        goto_idle();
        scan_chk("idcode_after_tms", 32, 64'd0, 64'(IDCODE_V));

        n = 0;
        while (req_exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_val("req_drain", 64'(req_exp_q.size()), 64'd0);
        check_val("req_stable", 64'(stable_err), 64'd0);
        check_val("handshakes", 64'(hs_cnt), 64'd5);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
